hssi_axis_lpbk_buf: RTL and testbench

Store-and-forward AXI-S packet loopback buffer for the HE-HSSI datapath.
- Consumes the 64-bit per-channel TX stream that he_hssi produces on hssi_ss_st_tx[i].tx.
- Replays each complete packet onto the matching hssi_ss_st_rx[i].rx stream.
- Gives RXLPBK tests a synthesizable loopback in place of the SS MAC.
- Egress has no backpressure, as with the MAC RX side, so packets leave only when fully buffered. Packets that do not fit are dropped whole.

---
 rtl/ofs_hssi_lpbk_pkg.sv | 26 ++
 rtl/hssi_lpbk_ram.sv | 23 ++
 rtl/hssi_axis_lpbk_buf.sv | 168 ++++++++++++++++
 tb/tb_hssi_axis_lpbk_buf.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_hssi_lpbk_pkg.sv
// Shared types for the HE-HSSI AXI-S loopback buffer: stored entry layout,
// egress FSM states and the ingress drop flag.
package ofs_hssi_lpbk_pkg;

  localparam int LPBK_DATA_W = 64;
  localparam int LPBK_USER_W = 12;

  typedef struct packed {
    logic [LPBK_DATA_W-1:0]   tdata;
    logic [LPBK_DATA_W/8-1:0] tkeep;
    logic [LPBK_USER_W-1:0]   tuser;
    logic                     tlast;
  } lpbk_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } egr_state_t;

  typedef enum logic {
    ING_PASS,
    ING_DROP
  } ing_drop_t;

endpackage

// File: rtl/hssi_lpbk_ram.sv
// Simple dual-port RAM with a registered one-cycle read; a read of the address
// being written in the same cycle returns undefined data.
module hssi_lpbk_ram #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 85
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hssi_axis_lpbk_buf.sv
// Store-and-forward AXI-S loopback: buffers whole packets from the TX stream and
// replays them without backpressure; packets that do not fit are dropped whole.
module hssi_axis_lpbk_buf
  import ofs_hssi_lpbk_pkg::*;
#(
  parameter int DATA_W     = LPBK_DATA_W,
  parameter int USER_W     = LPBK_USER_W,
  parameter int DEPTH_LOG2 = 9,
  parameter int IPG_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic [DATA_W/8-1:0]   s_tkeep,
  input  logic [USER_W-1:0]     s_tuser,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  output logic [DATA_W-1:0]     m_tdata,
  output logic [DATA_W/8-1:0]   m_tkeep,
  output logic [USER_W-1:0]     m_tuser,
  output logic                  m_tlast,
  output logic [31:0]           pkt_lpbk_cnt,
  output logic [31:0]           pkt_drop_cnt,
  output logic [DEPTH_LOG2:0]   buf_level
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PW-1:0] wr_ptr_reg, wr_commit_reg, rd_ptr_reg, pkt_avail_reg;
  logic [PW-1:0] level;
  ing_drop_t     drop_reg;
  egr_state_t    state_reg, state_next;
  logic [3:0]    gap_cnt_reg;
  logic          s_tready_reg, rd_vld_reg;
  logic          accept, wr_en, commit, rd_en, rd_is_last, egr_last;
  lpbk_entry_t   wr_entry, rd_entry;

  // tlast flags mirrored in fabric so SEND knows the packet end at issue time
  logic last_mem [2**DEPTH_LOG2];

  assign level      = wr_ptr_reg - rd_ptr_reg;
  assign buf_level  = level;
  assign s_tready   = s_tready_reg;
  assign accept     = s_tvalid && s_tready_reg;
  assign wr_en      = accept && (drop_reg == ING_PASS) && !((level == DEPTH) && !rd_en);
  assign commit     = wr_en && s_tlast;
  assign rd_is_last = last_mem[rd_ptr_reg[DEPTH_LOG2-1:0]];
  assign egr_last   = rd_en && rd_is_last;

  always_comb begin
    wr_entry       = '0;
    wr_entry.tdata = s_tdata;
    wr_entry.tkeep = s_tkeep;
    wr_entry.tuser = s_tuser;
    wr_entry.tlast = s_tlast;
  end

  hssi_lpbk_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  ($bits(lpbk_entry_t))
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg[DEPTH_LOG2-1:0]),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[DEPTH_LOG2-1:0]),
    .rd_data (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (wr_en) last_mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= s_tlast;
  end

  // Ingress: an overflowing beat rewinds to the last commit point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tready_reg  <= 1'b0;
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      drop_reg      <= ING_PASS;
      pkt_drop_cnt  <= '0;
    end else begin
      s_tready_reg <= 1'b1;
      if (accept) begin
        if (drop_reg == ING_DROP) begin
          if (s_tlast) begin
            pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
            drop_reg     <= ING_PASS;
          end
        end else if (!wr_en) begin
          wr_ptr_reg <= wr_commit_reg;
          if (s_tlast) pkt_drop_cnt <= pkt_drop_cnt + 32'd1;
          else         drop_reg     <= ING_DROP;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (s_tlast) wr_commit_reg <= wr_ptr_reg + 1'b1;
        end
      end
    end
  end

  // The last GAP cycle (or the tlast issue when IPG_CYCLES=0) stands in for IDLE,
  // so exactly IPG_CYCLES idle beats separate queued packets on egress.
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    case (state_reg)
      IDLE: if (pkt_avail_reg != '0) state_next = SEND;
      SEND: begin
        rd_en = 1'b1;
        if (rd_is_last) begin
          if (IPG_CYCLES != 0)              state_next = GAP;
          else if (pkt_avail_reg > PW'(1)) state_next = SEND;
          else                             state_next = IDLE;
        end
      end
      GAP: if (gap_cnt_reg == 4'd0) state_next = (pkt_avail_reg != '0) ? SEND : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= '0;
      rd_ptr_reg    <= '0;
      pkt_avail_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pkt_avail_reg <= pkt_avail_reg + {{(PW-1){1'b0}}, commit} - {{(PW-1){1'b0}}, egr_last};
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (egr_last)                                gap_cnt_reg <= 4'(IPG_CYCLES - 1);
      else if (state_reg == GAP && gap_cnt_reg != 0) gap_cnt_reg <= gap_cnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_reg   <= 1'b0;
      m_tvalid     <= 1'b0;
      m_tdata      <= '0;
      m_tkeep      <= '0;
      m_tuser      <= '0;
      m_tlast      <= 1'b0;
      pkt_lpbk_cnt <= '0;
    end else begin
      rd_vld_reg <= rd_en;
      m_tvalid   <= rd_vld_reg;
      if (rd_vld_reg) begin
        m_tdata <= rd_entry.tdata;
        m_tkeep <= rd_entry.tkeep;
        m_tuser <= rd_entry.tuser;
        m_tlast <= rd_entry.tlast;
        if (rd_entry.tlast) pkt_lpbk_cnt <= pkt_lpbk_cnt + 32'd1;
      end else begin
        m_tdata <= '0;
        m_tkeep <= '0;
        m_tuser <= '0;
        m_tlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hssi_axis_lpbk_buf.sv
// Scoreboard bench for hssi_axis_lpbk_buf: directed packet cases plus random
// traffic, expected beats queued at issue and matched by a monitor.
module tb_hssi_axis_lpbk_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [11:0] s_tuser;
  logic        m_tvalid, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [11:0] m_tuser;
  logic [31:0] pkt_lpbk_cnt, pkt_drop_cnt;
  logic [9:0]  buf_level;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hssi_axis_lpbk_buf #(
    .DATA_W(64), .USER_W(12), .DEPTH_LOG2(9), .IPG_CYCLES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tuser(m_tuser), .m_tlast(m_tlast),
    .pkt_lpbk_cnt(pkt_lpbk_cnt), .pkt_drop_cnt(pkt_drop_cnt), .buf_level(buf_level)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic [11:0] u;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  int exp_lpbk = 0, exp_drop = 0;
  int first_cyc = -1, last_tlast_cyc = -1, last_gap = -1, tlast_edge = 0, max_level = 0;
  bit in_pkt = 0, seen_tlast = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic monitor();
    beat_t act, exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (int'(buf_level) > max_level) max_level = int'(buf_level);
        act = {m_tdata, m_tkeep, m_tuser, m_tlast};
        if (m_tvalid) begin
          if (!in_pkt) begin
            first_cyc = cyc;
            if (seen_tlast) last_gap = cyc - last_tlast_cyc - 1;
            in_pkt = 1;
          end
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m_tdata);
          end else begin
            exp = exp_q.pop_front();
            check("egress_beat", act, exp);
            $display("beat cyc=%0d data=%0h keep=%0h user=%0h last=%0b", cyc, m_tdata, m_tkeep, m_tuser, m_tlast);
          end
          if (m_tlast) begin
            in_pkt = 0;
            seen_tlast = 1;
            last_tlast_cyc = cyc;
          end
        end else begin
          if (in_pkt) begin
            n_chk++;
            $display("FAIL contiguous: m_tvalid 0 mid-packet, required 1");
            in_pkt = 0;
          end
          check("idle_zero", act, 128'd0);
        end
      end
    end
  endtask

  // mode 0: tdata = 1..len, last tkeep 0x0F; mode 1: random data/keep
  task automatic send_pkt(input int len, input int mode, input bit pass, input logic [11:0] user);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = (mode == 0) ? 64'(i + 1) : {$urandom, $urandom};
      b.k = (i != len - 1) ? 8'hFF : ((mode == 0) ? 8'h0F : 8'($urandom_range(1, 255)));
      b.u = user;
      b.l = (i == len - 1);
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata = b.d; s_tkeep = b.k; s_tuser = b.u; s_tlast = b.l;
      if (pass) exp_q.push_back(b);
      if (b.l) begin
        tlast_edge = cyc + 1;
        if (pass) exp_lpbk++;
        else exp_drop++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s_drain: %0d beats missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
    check({name, "_lpbk_cnt"}, pkt_lpbk_cnt, exp_lpbk);
    check({name, "_drop_cnt"}, pkt_drop_cnt, exp_drop);
    check({name, "_buf_level"}, buf_level, 0);
  endtask

  initial begin
    s_tvalid = 0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_lpbk", pkt_lpbk_cnt, 0);
    check("rst_drop", pkt_drop_cnt, 0);
    check("rst_level", buf_level, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_up", s_tready, 1);

    send_pkt(8, 0, 1, 12'hABC);
    idle(1);
    drain("pkt8");
    check("pkt8_latency", first_cyc - tlast_edge, 3);

    seen_tlast = 0; last_gap = -1;
    send_pkt(4, 1, 1, 12'h111);
    send_pkt(4, 1, 1, 12'h222);
    idle(1);
    drain("b2b");
    check("b2b_ipg", last_gap, 1);

    send_pkt(513, 1, 0, 12'h333);
    idle(20);
    check("ovf_level", buf_level, 0);
    check("ovf_drop", pkt_drop_cnt, 1);
    send_pkt(2, 1, 1, 12'h444);
    idle(1);
    drain("after_ovf");

    max_level = 0;
    send_pkt(512, 1, 1, 12'h555);
    idle(1);
    drain("pkt512");
    check("pkt512_peak", max_level, 512);

    send_pkt(1, 1, 1, 12'h666);
    idle(1);
    drain("single");
    check("single_latency", first_cyc - tlast_edge, 3);

    for (int p = 0; p < 20; p++) begin
      send_pkt($urandom_range(1, 48), 1, 1, 12'($urandom));
      idle($urandom_range(0, 3));
    end
    idle(1);
    drain("random");

    send_pkt(16, 1, 1, 12'h777);
    idle(1);
    begin
      int t = 0;
      while (!in_pkt && t < 100) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (4) @(negedge clk);
    check("pre_rst_valid", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_tvalid, 0);
    check("midrst_lpbk", pkt_lpbk_cnt, 0);
    check("midrst_drop", pkt_drop_cnt, 0);
    check("midrst_level", buf_level, 0);
    exp_q.delete();
    in_pkt = 0; seen_tlast = 0; exp_lpbk = 0; exp_drop = 0;
    @(negedge clk);
    check("midrst_tready", s_tready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    send_pkt(3, 0, 1, 12'h888);
    idle(1);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
